alu_bist: RTL and testbench

Built-in self-test sequencer for the `alu`. It acts as the initiator on the ALU operand/control interface: it walks a fixed vector table, drives `a`/`b`/`alu_control`, samples `result`/`zero`, and compares both against expected values. It sits beside the `alu` in the datapath and is used at bring-up and in regression to prove the shift, arithmetic and compare paths before the core runs code.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 34 +++
 rtl/alu_bist_rom.sv | 25 ++
 rtl/alu_bist.sv | 108 ++++++++++
 tb/tb_alu_bist.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Opcodes shared by the ALU and its self-test, plus the self-test vector and FSM types.
// Pure declarations: no timing and no flow control.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam int NUM_VECTORS_MAX = 8;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vector_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; result and zero settle in the same cycle as the operands.
// No handshake: the consumer samples whenever it needs the result.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            alu_control,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    always_comb begin
        result = '0;
        case (alu_control)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $signed(a) >>> b[4:0];
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_bist_rom.sv
// Fixed self-test vector table, combinational index to vector lookup.
// No flow control; indices past the table return an all-zero ADD vector.
module alu_bist_rom
    import alu_pkg::*;
(
    input  logic [2:0] idx,
    output vector_t    vec
);

    always_comb begin
        vec = '{op: OP_ADD, a: 32'h0, b: 32'h0, expected: 32'h0};
        case (idx)
            3'd0: vec = '{op: OP_ADD, a: 32'd7,          b: 32'd5,          expected: 32'd12};
            3'd1: vec = '{op: OP_SUB, a: 32'd5,          b: 32'd5,          expected: 32'd0};
            3'd2: vec = '{op: OP_SLL, a: 32'd1,          b: 32'd4,          expected: 32'h0000_0010};
            3'd3: vec = '{op: OP_SRA, a: 32'h8000_0000,  b: 32'd4,          expected: 32'hF800_0000};
            3'd4: vec = '{op: OP_SLT, a: 32'd5,          b: 32'd10,         expected: 32'd1};
            3'd5: vec = '{op: OP_SLT, a: 32'hFFFF_FFFF,  b: 32'd1,          expected: 32'd1};
            3'd6: vec = '{op: OP_XOR, a: 32'hFFFF_0000,  b: 32'h0F0F_0F0F,  expected: 32'hF0F0_0F0F};
            3'd7: vec = '{op: OP_SRL, a: 32'h8000_0000,  b: 32'd4,          expected: 32'h0800_0000};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: two cycles per vector (load, check); done rises 2*NUM_VECTORS edges after start.
// start is only honoured in IDLE/DONE; the attached ALU must answer combinationally within one cycle.
module alu_bist
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_VECTORS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            fail_count,
    output logic [7:0]            first_fail_idx
);

    localparam logic [2:0] IDX_LAST = 3'(NUM_VECTORS - 1);

    bist_state_t state, state_nxt;
    logic [2:0]  idx;
    vector_t     vec;
    logic        mismatch;
    logic        last;
    logic [7:0]  fail_count_nxt;

    alu_bist_rom u_rom (
        .idx (idx),
        .vec (vec)
    );

    // The zero flag is checked independently so a broken flag path is caught even when the result is right.
    assign mismatch       = (alu_result != vec.expected) || (alu_zero != (vec.expected == 32'h0));
    assign last           = (idx == IDX_LAST);
    assign fail_count_nxt = (mismatch && fail_count != 8'hFF) ? fail_count + 8'd1 : fail_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last ? ST_DONE : ST_LOAD;
            ST_DONE:  if (start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_control    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= 8'hFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx            <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= 8'hFF;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    alu_a       <= vec.a;
                    alu_b       <= vec.b;
                    alu_control <= vec.op;
                end
                ST_CHECK: begin
                    fail_count <= fail_count_nxt;
                    if (mismatch && first_fail_idx == 8'hFF) begin
                        first_fail_idx <= {5'd0, idx};
                    end
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (fail_count_nxt == 8'd0);
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench: alu_bist driving the golden alu, with selectable fault overrides on the result/zero path.
module tb_alu_bist;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result, gold_result;
    logic        alu_zero, gold_zero;
    logic        busy, done, pass;
    logic [7:0]  fail_count, first_fail_idx;
    int          fault;
    int          errors;
    int          checks;

    alu #(.DATA_WIDTH(32)) u_alu (
        .a           (alu_a),
        .b           (alu_b),
        .alu_control (alu_control),
        .result      (gold_result),
        .zero        (gold_zero)
    );

    alu_bist #(.DATA_WIDTH(32), .NUM_VECTORS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_control    (alu_control),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx)
    );

    // 1: SRA behaves as SRL, 2: zero stuck at 0, 3: result stuck at 0 with a consistent zero flag
    always_comb begin
        alu_result = gold_result;
        alu_zero   = gold_zero;
        case (fault)
            1: if (alu_control == OP_SRA) begin
                   alu_result = alu_a >> alu_b[4:0];
                   alu_zero   = (alu_result == 32'h0);
               end
            2: alu_zero = 1'b0;
            3: begin
                   alu_result = 32'h0;
                   alu_zero   = 1'b1;
               end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start, optionally re-pulse it during the first CHECK, and check the E15/E16 boundary.
    task automatic do_run(input string tag, input logic [7:0] exp_fc, input logic [7:0] exp_ffi,
                          input logic exp_pass, input bit glitch);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, ".busy_after_e0"}, 32'(busy), 32'd1);
        check({tag, ".done_after_e0"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, ".vec0_a"}, alu_a, 32'd7);
        check({tag, ".vec0_ctrl"}, 32'(alu_control), 32'(OP_ADD));
        if (glitch) start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (13) @(negedge clk);
        check({tag, ".done_e15"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, ".done_e16"}, 32'(done), 32'd1);
        check({tag, ".busy_e16"}, 32'(busy), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        check({tag, ".fail_count"}, 32'(fail_count), 32'(exp_fc));
        check({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'(exp_ffi));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".alu_a"}, alu_a, 32'h0);
        check({tag, ".alu_b"}, alu_b, 32'h0);
        check({tag, ".alu_control"}, 32'(alu_control), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".fail_count"}, 32'(fail_count), 32'd0);
        check({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'hFF);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fault  = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Golden ALU, with a start glitch during CHECK that must be ignored
        do_run("golden", 8'd0, 8'hFF, 1'b1, 1'b1);
        check("golden.hold_a", alu_a, 32'h8000_0000);
        check("golden.hold_b", alu_b, 32'd4);
        check("golden.hold_ctrl", 32'(alu_control), 32'(OP_SRL));
        repeat (3) @(negedge clk);
        check("golden.done_held", 32'(done), 32'd1);

        fault = 1;
        do_run("sra_logical", 8'd1, 8'd3, 1'b0, 1'b0);
        fault = 2;
        do_run("zero_stuck0", 8'd1, 8'd1, 1'b0, 1'b0);
        fault = 3;
        do_run("result_stuck0", 8'd7, 8'd0, 1'b0, 1'b0);

        // Restart straight from DONE: counters from the failing run must clear on E0
        fault = 0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart.done", 32'(done), 32'd0);
        check("restart.busy", 32'(busy), 32'd1);
        check("restart.fail_count", 32'(fail_count), 32'd0);
        check("restart.first_fail_idx", 32'(first_fail_idx), 32'hFF);
        repeat (15) @(negedge clk);
        check("restart.done_e15", 32'(done), 32'd0);
        @(negedge clk);
        check("restart.done_e16", 32'(done), 32'd1);
        check("restart.pass", 32'(pass), 32'd1);
        check("restart.fail_count_end", 32'(fail_count), 32'd0);

        // Abort mid-run with reset, then a clean run
        fault = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        repeat (2) @(negedge clk);
        check("midrun.no_resume", 32'(busy), 32'd0);
        do_run("after_reset", 8'd0, 8'hFF, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
